// File: rtl/inference_scheduler.sv
// Sequencer for one digit inference: fc1, then fc2, then a 10-cycle argmax over fc2's bytes.
// Owns the shared ROM address and MultAdder operand ports and routes them to the active layer.
module inference_scheduler #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 11,
  parameter int VEC_W   = 1024
) (
  input  logic              clk,
  input  logic              iRst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic [3:0]        digit,
  output logic              fc1_ena,
  output logic              fc2_ena,
  output logic              fc1_rst_n,
  output logic              fc2_rst_n,
  input  logic              fc1_done,
  input  logic              fc2_done,
  input  logic              fc1_ovf,
  input  logic              fc2_ovf,
  input  logic [ADDR_W-1:0] fc1_addr,
  input  logic [ADDR_W-1:0] fc2_addr,
  input  logic [VEC_W-1:0]  fc1_opr1,
  input  logic [VEC_W-1:0]  fc1_opr2,
  input  logic [VEC_W-1:0]  fc2_opr1,
  input  logic [VEC_W-1:0]  fc2_opr2,
  input  logic [79:0]       fc2_out,
  output logic [ADDR_W-1:0] addr_to_rom,
  output logic [VEC_W-1:0]  opr1_to_MultAdder,
  output logic [VEC_W-1:0]  opr2_to_MultAdder
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FC1_RST, S_FC1_RUN, S_FC2_RST, S_FC2_RUN, S_ARGMAX, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [79:0]     scores;
  logic [3:0]      arg_idx;
  logic [3:0]      best_idx;
  logic [6:0]      best_key;
  logic [6:0]      cur_key;
  logic            cur_better;
  logic            wd_expired;

  // Negative bytes (bit 7 set) are relu'd to zero before comparison.
  assign cur_key    = scores[7] ? 7'd0 : scores[6:0];
  assign cur_better = (cur_key > best_key);
  assign wd_expired = (wd_cnt >= WD_LAST);

  // start is a single-cycle request with no ready: it is taken only when busy is low,
  // and a request arriving while busy is dropped, not queued.
  always_comb begin
    state_nxt         = state;
    busy              = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    fc1_ena           = 1'b0;
    fc2_ena           = 1'b0;
    fc1_rst_n         = 1'b1;
    fc2_rst_n         = 1'b1;
    addr_to_rom       = '0;
    opr1_to_MultAdder = '0;
    opr2_to_MultAdder = '0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state == S_DONE);
        err  = (state == S_ERR);
        if (start) state_nxt = S_FC1_RST;
      end
      S_FC1_RST, S_FC1_RUN: begin
        busy              = 1'b1;
        fc1_ena           = 1'b1;
        fc1_rst_n         = (state == S_FC1_RUN);
        addr_to_rom       = fc1_addr;
        opr1_to_MultAdder = fc1_opr1;
        opr2_to_MultAdder = fc1_opr2;
        if (state == S_FC1_RST)  state_nxt = S_FC1_RUN;
        else if (fc1_done)       state_nxt = S_FC2_RST;
        else if (wd_expired)     state_nxt = S_ERR;
      end
      S_FC2_RST, S_FC2_RUN: begin
        busy              = 1'b1;
        fc2_ena           = 1'b1;
        fc2_rst_n         = (state == S_FC2_RUN);
        addr_to_rom       = fc2_addr;
        opr1_to_MultAdder = fc2_opr1;
        opr2_to_MultAdder = fc2_opr2;
        if (state == S_FC2_RST)  state_nxt = S_FC2_RUN;
        else if (fc2_done)       state_nxt = S_ARGMAX;
        else if (wd_expired)     state_nxt = S_ERR;
      end
      S_ARGMAX: begin
        busy = 1'b1;
        if (arg_idx == 4'd9) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      overflow <= 1'b0;
      digit    <= 4'd0;
      scores   <= '0;
      arg_idx  <= 4'd0;
      best_idx <= 4'd0;
      best_key <= 7'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            overflow <= 1'b0;
            wd_cnt   <= '0;
          end
        end
        S_FC1_RST, S_FC2_RST: wd_cnt <= '0;
        S_FC1_RUN: begin
          overflow <= overflow | fc1_ovf;
          if (wd_cnt < WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        end
        S_FC2_RUN: begin
          overflow <= overflow | fc2_ovf;
          if (wd_cnt < WD_MAX) wd_cnt <= wd_cnt + 1'b1;
          if (fc2_done) begin
            scores   <= fc2_out;
            arg_idx  <= 4'd0;
            best_idx <= 4'd0;
            best_key <= 7'd0;
          end
        end
        S_ARGMAX: begin
          // Bytes are consumed from the bottom of the captured word, one per cycle.
          scores  <= scores >> 8;
          arg_idx <= arg_idx + 4'd1;
          if (cur_better) begin
            best_key <= cur_key;
            best_idx <= arg_idx;
          end
          if (arg_idx == 4'd9) digit <= cur_better ? arg_idx : best_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// Bench for inference_scheduler: behavioural layer models, table of directed inferences,
// randomized inferences against a timeline/argmax reference model, and reset/timeout sequences.
module tb_inference_scheduler;

  localparam int TO     = 64;
  localparam int ADDR_W = 11;
  localparam int VEC_W  = 1024;

  logic clk = 1'b0;
  logic iRst_n, start;
  logic busy, done, err, overflow;
  logic [3:0] digit;
  logic fc1_ena, fc2_ena, fc1_rst_n, fc2_rst_n;
  logic fc1_done, fc2_done, fc1_ovf, fc2_ovf;
  logic [ADDR_W-1:0] fc1_addr, fc2_addr, addr_to_rom;
  logic [VEC_W-1:0] fc1_opr1, fc1_opr2, fc2_opr1, fc2_opr2;
  logic [VEC_W-1:0] opr1_to_MultAdder, opr2_to_MultAdder;
  logic [79:0] fc2_out;

  int n_checks = 0;
  int n_errors = 0;

  // Layer models: done is raised once L enabled, out-of-reset cycles have elapsed.
  int l1_len = 0, l2_len = 0, cnt1 = 0, cnt2 = 0;
  bit l2_hang = 1'b0;

  inference_scheduler #(.TIMEOUT(TO), .ADDR_W(ADDR_W), .VEC_W(VEC_W)) dut (
    .clk(clk), .iRst_n(iRst_n), .start(start), .busy(busy), .done(done), .err(err),
    .overflow(overflow), .digit(digit), .fc1_ena(fc1_ena), .fc2_ena(fc2_ena),
    .fc1_rst_n(fc1_rst_n), .fc2_rst_n(fc2_rst_n), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .fc1_ovf(fc1_ovf), .fc2_ovf(fc2_ovf), .fc1_addr(fc1_addr), .fc2_addr(fc2_addr),
    .fc1_opr1(fc1_opr1), .fc1_opr2(fc1_opr2), .fc2_opr1(fc2_opr1), .fc2_opr2(fc2_opr2),
    .fc2_out(fc2_out), .addr_to_rom(addr_to_rom),
    .opr1_to_MultAdder(opr1_to_MultAdder), .opr2_to_MultAdder(opr2_to_MultAdder)
  );

  // Clock and layer models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!fc1_rst_n) cnt1 <= 0; else if (fc1_ena) cnt1 <= cnt1 + 1;
    if (!fc2_rst_n) cnt2 <= 0; else if (fc2_ena) cnt2 <= cnt2 + 1;
  end
  assign fc1_done = fc1_ena && fc1_rst_n && (cnt1 == l1_len);
  assign fc2_done = fc2_ena && fc2_rst_n && !l2_hang && (cnt2 == l2_len);

  typedef struct {
    int          l1;
    int          l2;
    logic [79:0] sc;
    int          o1;
    int          o2;
    int          bstart;
    logic [3:0]  exp_digit;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [VEC_W-1:0] rnd_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference argmax: relu each byte, first strictly-largest wins.
  function automatic logic [3:0] ref_digit(input logic [79:0] sc);
    int best = 0;
    int best_val = -1;
    for (int i = 0; i < 10; i++) begin
      logic [79:0] sh;
      int val;
      sh  = sc >> (8 * i);
      val = sh[7] ? 0 : int'(sh[6:0]);
      if (val > best_val) begin
        best_val = val;
        best = i;
      end
    end
    return 4'(best);
  endfunction

  // One inference. k counts cycles after the one carrying start; the reference timeline is
  // fc1 reset at k=1, fc1 run to l1+2, fc2 reset at l1+3, fc2 run to l1+l2+4, argmax, done at l1+l2+15.
  task automatic run_inf(input string nm, input int l1, input int l2, input logic [79:0] sc,
                         input int o1, input int o2, input bit hang, input int bstart,
                         input int rst_at, input logic [3:0] exp_digit, input logic exp_ovf);
    int f1_end, f2_end, term_k;
    bit ended;
    logic e1, e2;
    logic [ADDR_W-1:0] e_addr;
    logic [VEC_W-1:0] e_o1, e_o2;
    l1_len = l1; l2_len = l2; l2_hang = hang; fc2_out = sc;
    fc1_addr = ADDR_W'($urandom); fc2_addr = ADDR_W'($urandom);
    fc1_opr1 = rnd_vec(); fc1_opr2 = rnd_vec(); fc2_opr1 = rnd_vec(); fc2_opr2 = rnd_vec();
    f1_end = l1 + 2;
    f2_end = hang ? l1 + 3 + TO : l1 + l2 + 4;
    term_k = hang ? f2_end + 1 : l1 + l2 + 15;
    @(negedge clk);
    start = 1'b1;
    ended = 1'b0;
    for (int k = 1; k <= 400 && !ended; k++) begin
      @(negedge clk);
      start = (k == bstart);
      if (rst_at > 0 && k == rst_at + 1) begin
        chk({nm, " reset ctl"}, {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0000101);
        chk({nm, " reset ovf/digit"}, {overflow, digit}, 5'd0);
        chk({nm, " reset mux"}, {addr_to_rom, 1'(opr1_to_MultAdder == '0 && opr2_to_MultAdder == '0)},
            {{ADDR_W{1'b0}}, 1'b1});
        iRst_n = 1'b1;
        ended = 1'b1;
      end else if (k == term_k) begin
        if (hang) begin
          chk({nm, " err ctl"}, {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0010101);
        end else begin
          chk({nm, " done ctl"}, {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0100101);
          chk({nm, " digit"}, digit, exp_digit);
          chk({nm, " overflow"}, overflow, exp_ovf);
        end
        ended = 1'b1;
      end else begin
        e1 = (k <= f1_end);
        e2 = (k >= l1 + 3) && (k <= f2_end);
        e_addr = e1 ? fc1_addr : (e2 ? fc2_addr : '0);
        e_o1   = e1 ? fc1_opr1 : (e2 ? fc2_opr1 : '0);
        e_o2   = e1 ? fc1_opr2 : (e2 ? fc2_opr2 : '0);
        chk($sformatf("%s k=%0d ctl", nm, k), {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n},
            {1'b1, 1'b0, 1'b0, e1, 1'(k != 1), e2, 1'(k != l1 + 3)});
        chk($sformatf("%s k=%0d addr", nm, k), addr_to_rom, e_addr);
        chk($sformatf("%s k=%0d opr", nm, k),
            1'(opr1_to_MultAdder === e_o1 && opr2_to_MultAdder === e_o2), 1'b1);
        if (k == 1) chk({nm, " overflow cleared"}, overflow, 1'b0);
      end
      if (!ended) begin
        // Outside its own run window a layer's flag floats, so drive noise there.
        fc1_ovf = (k >= 2 && k <= f1_end) ? 1'(k == o1) : 1'($urandom_range(0, 1));
        fc2_ovf = (k >= l1 + 4 && k <= f2_end) ? 1'(k == o2) : 1'($urandom_range(0, 1));
        if (k > f2_end) fc2_out = {$urandom, $urandom, 16'($urandom)};
        if (k == rst_at) iRst_n = 1'b0;
      end
    end
    if (!ended) chk({nm, " completion bound"}, 1'b0, 1'b1);
    start = 1'b0; fc1_ovf = 1'b0; fc2_ovf = 1'b0;
  endtask

  initial begin
    logic [79:0] sc;
    int l1, l2, o1, o2;

    vecs[0] = '{40, 25, {8'h30, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h55, 8'h10, 8'h10, 8'h10},
                -1, -1, -1, 4'd3, 1'b0};
    vecs[1] = '{10, 8, {8'h10, 8'h10, 8'h55, 8'h10, 8'h80, 8'h10, 8'h10, 8'h55, 8'h10, 8'h10},
                5, -1, 7, 4'd2, 1'b1};
    vecs[2] = '{3, 1, {8'h80, 8'hFF, 8'h90, 8'h80, 8'h80, 8'hA0, 8'h80, 8'h80, 8'h80, 8'h80},
                -1, -1, -1, 4'd0, 1'b0};
    vecs[3] = '{0, 0, {8'h7F, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h00, 8'h7E},
                -1, 4, -1, 4'd9, 1'b1};
    vecs[4] = '{40, 25, {8'h10, 8'h7F, 8'h00, 8'h7F, 8'h10, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10},
                -1, 60, 50, 4'd6, 1'b1};

    iRst_n = 1'b0; start = 1'b0; fc1_ovf = 1'b0; fc2_ovf = 1'b0; fc2_out = '0;
    fc1_addr = '0; fc2_addr = '0; fc1_opr1 = '0; fc1_opr2 = '0; fc2_opr1 = '0; fc2_opr2 = '0;
    repeat (3) @(negedge clk);
    chk("reset ctl", {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0000101);
    chk("reset ovf/digit", {overflow, digit}, 5'd0);
    chk("reset addr", addr_to_rom, '0);
    iRst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_inf($sformatf("vec%0d", i), vecs[i].l1, vecs[i].l2, vecs[i].sc, vecs[i].o1, vecs[i].o2,
              1'b0, vecs[i].bstart, -1, vecs[i].exp_digit, vecs[i].exp_ovf);

    // Reset mid fc2 run (overflow already set by fc1, digit left at 6 by the last run).
    run_inf("rst_fc2", 20, 30, {10{8'h11}}, 5, -1, 1'b0, -1, 20 + 4 + 10, 4'd0, 1'b0);

    // fc2 never finishes: watchdog abort, then a clean recovery run.
    run_inf("timeout", 40, 0, {10{8'h22}}, -1, -1, 1'b1, -1, -1, 4'd0, 1'b0);
    run_inf("recover", 40, 25, vecs[0].sc, -1, -1, 1'b0, -1, -1, 4'd3, 1'b0);

    for (int r = 0; r < 8; r++) begin
      l1 = $urandom_range(0, 30);
      l2 = $urandom_range(0, 30);
      sc = {$urandom, $urandom, 16'($urandom)};
      o1 = $urandom_range(0, 1) ? $urandom_range(2, l1 + 2) : -1;
      o2 = $urandom_range(0, 1) ? $urandom_range(l1 + 4, l1 + l2 + 4) : -1;
      run_inf($sformatf("rnd%0d", r), l1, l2, sc, o1, o2, 1'b0,
              $urandom_range(0, 1) ? $urandom_range(2, l1 + l2 + 14) : -1, -1,
              ref_digit(sc), 1'(o1 > 0 || o2 > 0));
    end

    // Reset and start together from DONE: reset wins.
    @(negedge clk);
    iRst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("rst+start ctl", {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0000101);
    iRst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst+start idle", {busy, done, err, fc1_ena, fc1_rst_n, fc2_ena, fc2_rst_n}, 7'b0000101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
